// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment constants and font lookup
package seg7_pkg;

  // All segments off (segments are active low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex font, {a,b,c,d,e,f,g}, active low, indexed by nibble value
  localparam logic [6:0] SEG7_FONT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // In BCD mode codes A-F have no glyph and are shown blank
  function automatic logic [6:0] seg7_font(input logic [3:0] nibble, input logic hex_mode);
    if (!hex_mode && (nibble > 4'd9)) return SEG_BLANK;
    return SEG7_FONT[nibble];
  endfunction

endpackage

// File: rtl/seg7_font_dec.sv
// rtl/seg7_font_dec.sv - combinational nibble to segment pattern decoder
module seg7_font_dec
  import seg7_pkg::*;
#(
  parameter int HEX_MODE = 1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  localparam logic HEX = (HEX_MODE != 0);

  assign seg = seg7_font(nibble, HEX);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment scanner with tear-free double buffer
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NDIGITS  = 8,
  parameter int SCAN_DIV = 1000,
  parameter int HEX_MODE = 1,
  parameter int GUARD    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   blank_lz,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [4*NDIGITS-1:0]   load_data,
  input  logic [NDIGITS-1:0]     load_dp,
  output logic [6:0]             seg_o,
  output logic                   dp_o,
  output logic [NDIGITS-1:0]     an_o,
  output logic                   frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [PW-1:0] PC_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PC_GUARD = PW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);

  logic [PW-1:0]          pc;
  logic [IW-1:0]          idx;
  logic [4*NDIGITS-1:0]   disp_data;
  logic [4*NDIGITS-1:0]   pend_data;
  logic [NDIGITS-1:0]     disp_dp;
  logic [NDIGITS-1:0]     pend_dp;
  logic                   pend_v;
  logic                   boundary;
  logic                   xfer;
  logic [3:0]             nibble;
  logic [6:0]             font_seg;
  logic [4*NDIGITS-1:0]   upper;
  logic                   blanked;

  assign boundary   = (pc == PC_LAST) && (idx == IDX_LAST);
  assign load_ready = ~pend_v;
  assign xfer       = load_valid && load_ready;

  // Current digit's nibble, and whether it and every digit above it are zero
  assign nibble  = disp_data[{idx, 2'b00} +: 4];
  assign upper   = disp_data >> {idx, 2'b00};
  assign blanked = blank_lz && (idx != '0) && (upper == '0);

  seg7_font_dec #(.HEX_MODE(HEX_MODE)) u_font (
    .nibble (nibble),
    .seg    (font_seg)
  );

  // Prescaler sets the slot length; the digit index advances once per slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= '0;
      idx <= '0;
    end else if (pc == PC_LAST) begin
      pc  <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pc  <= pc + 1'b1;
    end
  end

  // New words park in pending and only reach the display at a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_data <= '0;
      disp_dp   <= '0;
      pend_data <= '0;
      pend_dp   <= '0;
      pend_v    <= 1'b0;
    end else begin
      if (boundary && pend_v) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
        pend_v    <= 1'b0;
      end
      if (xfer) begin
        pend_data <= load_data;
        pend_dp   <= load_dp;
        pend_v    <= 1'b1;
      end
    end
  end

  // Registered pin drive; anodes stay dark for the first GUARD clocks of a slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o      <= SEG_BLANK;
      dp_o       <= 1'b1;
      an_o       <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (!en) begin
        seg_o <= SEG_BLANK;
        dp_o  <= 1'b1;
        an_o  <= '1;
      end else begin
        seg_o <= blanked ? SEG_BLANK : font_seg;
        dp_o  <= blanked | ~disp_dp[idx];
        an_o  <= (pc < PC_GUARD) ? '1 : ~(NDIGITS'(1) << idx);
      end
    end
  end

endmodule
